// File: rtl/muldiv_unit_pkg.sv
// Shared multiply/divide definitions: op encodings used by the ID-stage
// decoder, hazard unit and muldiv_unit, plus the FSM state encoding.
package muldiv_unit_pkg;

   localparam logic [1:0] MD_MULT  = 2'd0;
   localparam logic [1:0] MD_MULTU = 2'd1;
   localparam logic [1:0] MD_DIV   = 2'd2;
   localparam logic [1:0] MD_DIVU  = 2'd3;

   // start edge to HI/LO visible, identical for every op
   localparam int MD_LATENCY = 34;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PREP = 2'd1,
      ST_CALC = 2'd2,
      ST_FIX  = 2'd3
   } md_state_e;

   // MULT and DIV are the even encodings
   function automatic logic md_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic md_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// EX-stage <-> muldiv_unit bundle: request, MTHI/MTLO writes, status and HI/LO.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
) ();

   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, hi_we, lo_we, wdata,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wdata,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for start; MTHI/MTLO writes accepted here only
// PREP  | take magnitudes for signed ops, record signs, clear accumulator
// CALC  | 32 iterations of shift-add (mul) or restoring subtract (div)
// FIX   | sign-correct, write HI/LO, pulse done
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic           clk,
   input  logic           rst,
   muldiv_unit_if.slave   md
);

   localparam int CW = $clog2(WIDTH);

   md_state_e          state;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   a_raw;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;
   logic               neg_res;
   logic               neg_rem;
   logic               b_zero;
   logic               busy_q;
   logic               done_q;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;

   logic [WIDTH-1:0]   mul_addend;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic               div_ok;
   logic [WIDTH-1:0]   div_sub;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix;
   logic [WIDTH-1:0]   rem_fix;

   // Datapath: one shift-add / restoring step, and final sign correction.
   // The multiplier is consumed from b_q LSB-first; the dividend is fed
   // from a_q MSB-first into the partial remainder held in acc[hi].
   always_comb begin
      mul_addend = b_q[0] ? a_q : '0;
      mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
      div_shift  = {acc[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
      div_ok     = div_shift >= {1'b0, b_q};
      // when div_ok the true difference is below b, so WIDTH bits suffice
      div_sub    = div_shift[WIDTH-1:0] - b_q;
      prod_fix   = neg_res ? -acc : acc;
      quot_fix   = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix    = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   // Control FSM, iteration state and architectural HI/LO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         op_q    <= MD_MULT;
         a_q     <= '0;
         b_q     <= '0;
         a_raw   <= '0;
         acc     <= '0;
         cnt     <= '0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         b_zero  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (md.hi_we) hi_q <= md.wdata;
               if (md.lo_we) lo_q <= md.wdata;
               if (md.start) begin
                  op_q   <= md.op;
                  a_q    <= md.a;
                  b_q    <= md.b;
                  a_raw  <= md.a;
                  busy_q <= 1'b1;
                  state  <= ST_PREP;
               end
            end
            ST_PREP: begin
               if (md_is_signed(op_q)) begin
                  a_q     <= a_q[WIDTH-1] ? -a_q : a_q;
                  b_q     <= b_q[WIDTH-1] ? -b_q : b_q;
                  neg_res <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                  neg_rem <= a_q[WIDTH-1];
               end else begin
                  neg_res <= 1'b0;
                  neg_rem <= 1'b0;
               end
               b_zero <= (b_q == '0);
               acc    <= '0;
               cnt    <= CW'(WIDTH - 1);
               state  <= ST_CALC;
            end
            ST_CALC: begin
               if (md_is_div(op_q)) begin
                  acc <= {(div_ok ? div_sub : div_shift[WIDTH-1:0]),
                          acc[WIDTH-2:0], div_ok};
                  a_q <= a_q << 1;
               end else begin
                  acc <= {mul_sum, acc[WIDTH-1:1]};
                  b_q <= b_q >> 1;
               end
               cnt <= cnt - 1'b1;
               if (cnt == '0) state <= ST_FIX;
            end
            ST_FIX: begin
               if (md_is_div(op_q)) begin
                  if (b_zero) begin
                     lo_q <= '1;
                     hi_q <= a_raw;
                  end else begin
                     lo_q <= quot_fix;
                     hi_q <= rem_fix;
                  end
               end else begin
                  {hi_q, lo_q} <= prod_fix;
               end
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign md.busy = busy_q;
   assign md.done = done_q;
   assign md.hi   = hi_q;
   assign md.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
   import muldiv_unit_pkg::*;

   logic clk;
   logic rst;
   int   vectors;
   int   errors;

   muldiv_unit_if #(.WIDTH(32)) md ();

   muldiv_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .md  (md)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one op, confirm busy/done throughout, and check the result at edge 34.
   task automatic run_op(input string tag, input logic [1:0] t_op,
                         input logic [31:0] t_a, input logic [31:0] t_b,
                         input logic [63:0] exp);
      int bad;
      bad = 0;
      md.op = t_op;
      md.a = t_a;
      md.b = t_b;
      md.start = 1'b1;
      tick();
      md.start = 1'b0;
      md.a = $urandom;
      md.b = $urandom;
      check({tag, "_busy_e0"}, 64'(md.busy), 64'd1);
      for (int i = 1; i <= 33; i++) begin
         tick();
         if (md.busy !== 1'b1 || md.done !== 1'b0) bad++;
      end
      check({tag, "_inflight"}, 64'(bad), 64'd0);
      tick();
      check({tag, "_done"}, 64'(md.done), 64'd1);
      check({tag, "_busy_e34"}, 64'(md.busy), 64'd0);
      check({tag, "_hilo"}, {md.hi, md.lo}, exp);
      tick();
      check({tag, "_done_drop"}, 64'(md.done), 64'd0);
   endtask

   initial begin
      int dcount;
      vectors = 0;
      errors  = 0;
      rst = 1'b1;
      md.start = 1'b0;
      md.op = MD_MULT;
      md.a = '0;
      md.b = '0;
      md.hi_we = 1'b0;
      md.lo_we = 1'b0;
      md.wdata = '0;
      tick();
      tick();
      check("rst_busy", 64'(md.busy), 64'd0);
      check("rst_done", 64'(md.done), 64'd0);
      check("rst_hi", 64'(md.hi), 64'd0);
      check("rst_lo", 64'(md.lo), 64'd0);
      rst = 1'b0;
      tick();

      run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      run_op("mult_m3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op("mult_minsq", MD_MULT, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      run_op("div_m7d2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("divu_7d0", MD_DIVU, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF);
      run_op("div_m7d0", MD_DIV, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF);
      run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
      run_op("divu_1000d3", MD_DIVU, 32'd1000, 32'd3, 64'h0000_0001_0000_014D);

      // DIVU 100/7 with a second start at edge 5 that must be ignored
      md.op = MD_DIVU;
      md.a = 32'd100;
      md.b = 32'd7;
      md.start = 1'b1;
      tick();
      md.start = 1'b0;
      repeat (4) tick();
      md.op = MD_MULTU;
      md.a = 32'd2;
      md.b = 32'd3;
      md.start = 1'b1;
      tick();
      md.start = 1'b0;
      md.a = 32'h1234_5678;
      md.b = 32'h0000_0000;
      repeat (28) tick();
      check("ign_done_e33", 64'(md.done), 64'd0);
      tick();
      check("ign_done_e34", 64'(md.done), 64'd1);
      check("ign_hilo", {md.hi, md.lo}, 64'h0000_0002_0000_000E);

      // back-to-back: start driven during the done cycle
      md.op = MD_MULTU;
      md.a = 32'd2;
      md.b = 32'd3;
      md.start = 1'b1;
      tick();
      md.start = 1'b0;
      check("b2b_busy", 64'(md.busy), 64'd1);
      repeat (9) tick();
      md.hi_we = 1'b1;
      md.lo_we = 1'b1;
      md.wdata = 32'hDEAD_BEEF;
      tick();
      md.hi_we = 1'b0;
      md.lo_we = 1'b0;
      check("busy_mthi_ignored", {md.hi, md.lo}, 64'h0000_0002_0000_000E);
      repeat (23) tick();
      check("b2b_done_e33", 64'(md.done), 64'd0);
      tick();
      check("b2b_done_e34", 64'(md.done), 64'd1);
      check("b2b_hilo", {md.hi, md.lo}, 64'h0000_0000_0000_0006);
      tick();

      // MTHI / MTLO in IDLE
      md.hi_we = 1'b1;
      md.wdata = 32'hDEAD_BEEF;
      tick();
      md.hi_we = 1'b0;
      check("mthi", {md.hi, md.lo}, 64'hDEAD_BEEF_0000_0006);
      md.lo_we = 1'b1;
      md.wdata = 32'h1234_5678;
      tick();
      md.lo_we = 1'b0;
      check("mtlo", {md.hi, md.lo}, 64'hDEAD_BEEF_1234_5678);

      // MTLO together with start: write lands now, result overwrites at FIX
      md.op = MD_MULT;
      md.a = 32'hFFFF_FFFD;
      md.b = 32'd5;
      md.lo_we = 1'b1;
      md.wdata = 32'hCAFE_F00D;
      md.start = 1'b1;
      tick();
      md.start = 1'b0;
      md.lo_we = 1'b0;
      check("start_mtlo_lo", 64'(md.lo), 64'h0000_0000_CAFE_F00D);
      repeat (33) tick();
      tick();
      check("start_mtlo_done", 64'(md.done), 64'd1);
      check("start_mtlo_hilo", {md.hi, md.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      tick();

      // reset mid-operation discards the op and clears HI/LO
      md.op = MD_DIVU;
      md.a = 32'd100;
      md.b = 32'd7;
      md.start = 1'b1;
      tick();
      md.start = 1'b0;
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", 64'(md.busy), 64'd0);
      check("midrst_done", 64'(md.done), 64'd0);
      check("midrst_hilo", {md.hi, md.lo}, 64'd0);
      dcount = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (md.done !== 1'b0 || md.busy !== 1'b0) dcount++;
      end
      check("midrst_no_done", 64'(dcount), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
